// File: rtl/pipeline_id_stage.sv
// RV32I decode stage with load-use hazard detection and a registered ID/EX boundary.
// Immediates and PC are carried at XLEN width; the ALU control is zero-extended to ALU_CTRL_W.
module pipeline_id_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_inst,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_ready,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_imm,
    output logic [4:0]            ex_rs1,
    output logic [4:0]            ex_rs2,
    output logic [4:0]            ex_rd,
    output logic [1:0]            ex_alu_src_a,
    output logic                  ex_alu_src_b,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [1:0]            ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_reg_write,
    output logic                  ex_mem_rw,
    output logic                  ex_illegal
);

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_IMM    = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_R      = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011
    } opcode_e;

    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] imm32;
    logic [2:0]  fun3;
    logic [3:0]  alu4;
    logic [1:0]  src_a, m2r;
    logic        src_b, branch, jump, reg_write, mem_rw, illegal;
    logic        rs1_used, rs2_used;
    logic        hazard;

    assign rs1_addr = if_inst[19:15];
    assign rs2_addr = if_inst[24:20];
    assign fun3     = if_inst[14:12];

    assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
    assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
    assign imm_u = {if_inst[31:12], 12'b0};

    always_comb begin
        imm32     = '0;
        alu4      = '0;
        src_a     = 2'b00;
        src_b     = 1'b1;
        m2r       = 2'b00;
        branch    = 1'b0;
        jump      = 1'b0;
        reg_write = 1'b0;
        mem_rw    = 1'b0;
        illegal   = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        if (if_inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode_e'(if_inst[6:2]))
                OP_R: begin
                    src_b     = 1'b0;
                    alu4      = {if_inst[30], fun3};
                    reg_write = 1'b1;
                    rs1_used  = 1'b1;
                    rs2_used  = 1'b1;
                end
                OP_IMM: begin
                    imm32     = imm_i;
                    // inst[30] is an immediate bit except for the shift-right pair
                    alu4      = {(fun3 == 3'b101) & if_inst[30], fun3};
                    reg_write = 1'b1;
                    rs1_used  = 1'b1;
                end
                OP_LOAD: begin
                    imm32     = imm_i;
                    m2r       = 2'b01;
                    reg_write = 1'b1;
                    rs1_used  = 1'b1;
                end
                OP_STORE: begin
                    imm32    = imm_s;
                    mem_rw   = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end
                OP_BRANCH: begin
                    imm32    = imm_b;
                    src_b    = 1'b0;
                    alu4     = 4'b1000;
                    branch   = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end
                OP_JAL: begin
                    imm32     = imm_j;
                    src_a     = 2'b01;
                    m2r       = 2'b10;
                    jump      = 1'b1;
                    reg_write = 1'b1;
                end
                OP_JALR: begin
                    imm32     = imm_i;
                    m2r       = 2'b10;
                    jump      = 1'b1;
                    reg_write = 1'b1;
                    rs1_used  = 1'b1;
                end
                OP_LUI: begin
                    imm32     = imm_u;
                    src_a     = 2'b10;
                    reg_write = 1'b1;
                end
                OP_AUIPC: begin
                    imm32     = imm_u;
                    src_a     = 2'b01;
                    reg_write = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign hazard = ex_valid & (ex_mem_to_reg == 2'b01) & (ex_rd != 5'd0) & if_valid &
                    ((rs1_used & (rs1_addr == ex_rd)) | (rs2_used & (rs2_addr == ex_rd)));

    assign id_ready = ex_ready & ~hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_alu_src_a  <= '0;
            ex_alu_src_b  <= 1'b0;
            ex_alu_ctrl   <= '0;
            ex_mem_to_reg <= '0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_rw     <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_ready && hazard) begin
            ex_valid <= 1'b0;
        end else if (ex_ready) begin
            ex_valid      <= if_valid;
            ex_pc         <= if_pc;
            ex_imm        <= XLEN'($signed(imm32));
            ex_rs1        <= rs1_addr;
            ex_rs2        <= rs2_addr;
            ex_rd         <= if_inst[11:7];
            ex_alu_src_a  <= src_a;
            ex_alu_src_b  <= src_b;
            ex_alu_ctrl   <= ALU_CTRL_W'(alu4);
            ex_mem_to_reg <= m2r;
            ex_branch     <= branch;
            ex_jump       <= jump;
            ex_reg_write  <= reg_write;
            ex_mem_rw     <= mem_rw;
            ex_illegal    <= illegal;
        end
    end

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Self-checking bench for pipeline_id_stage: expected ID/EX contents are queued when an
// instruction is accepted and compared one cycle later when the register presents it.
module tb_pipeline_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready;
    logic        ex_ready = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_alu_src_a;
    logic        ex_alu_src_b;
    logic [3:0]  ex_alu_ctrl;
    logic [1:0]  ex_mem_to_reg;
    logic        ex_branch, ex_jump, ex_reg_write, ex_mem_rw, ex_illegal;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  src_a;
        logic        src_b;
        logic [3:0]  alu;
        logic [1:0]  m2r;
        logic        branch;
        logic        jump;
        logic        rw;
        logic        mrw;
        logic        illegal;
    } ex_t;

    ex_t exp_q[$];

    pipeline_id_stage #(.XLEN(32), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_reg_write(ex_reg_write), .ex_mem_rw(ex_mem_rw), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic ex_t snap();
        ex_t s;
        s = '{valid: ex_valid, pc: ex_pc, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
              src_a: ex_alu_src_a, src_b: ex_alu_src_b, alu: ex_alu_ctrl, m2r: ex_mem_to_reg,
              branch: ex_branch, jump: ex_jump, rw: ex_reg_write, mrw: ex_mem_rw,
              illegal: ex_illegal};
        return s;
    endfunction

    function automatic ex_t mk(logic [31:0] pc, logic [31:0] imm, logic [4:0] rs1,
                               logic [4:0] rs2, logic [4:0] rd, logic [1:0] sa, logic sb,
                               logic [3:0] alu, logic [1:0] m2r, logic br, logic j,
                               logic rw, logic mrw);
        ex_t e;
        e = '{valid: 1'b1, pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd, src_a: sa,
              src_b: sb, alu: alu, m2r: m2r, branch: br, jump: j, rw: rw, mrw: mrw,
              illegal: 1'b0};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        ex_t e, got;
        if_inst = 32'h0050_0093;
        ex_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (snap() !== ex_t'('0)) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", snap());
        end
        checks++;
        if ({rs1_addr, rs2_addr} !== {5'd0, 5'd5}) begin
            errors++;
            $display("FAIL reset_rs_addr: got %0d/%0d required 0/5", rs1_addr, rs2_addr);
        end
        #1 rst = 1'b0;
        ex_ready = 1'b1;
        drive(32'h0050_0093, 32'h100);
        exp_q.push_back(mk(32'h100, 32'd5, 5'd0, 5'd5, 5'd1, 2'b00, 1'b1, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL addi_after_reset: got %h required %h", got, e);
        end
        // asynchronous reset mid-cycle while ex_valid is high
        #2 rst = 1'b1;
        #1;
        checks++;
        if (snap() !== ex_t'('0)) begin
            errors++;
            $display("FAIL async_reset: got %h required 0", snap());
        end
        #1 rst = 1'b0;
        drive(32'h0050_0093, 32'h104);
        exp_q.push_back(mk(32'h104, 32'd5, 5'd0, 5'd5, 5'd1, 2'b00, 1'b1, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL addi_after_async_reset: got %h required %h", got, e);
        end
    endtask

    task automatic test_load_use();
        ex_t e, got;
        int unsigned n;
        drive(32'h0000_A103, 32'h300);
        exp_q.push_back(mk(32'h300, 32'd0, 5'd1, 5'd0, 5'd2, 2'b00, 1'b1, 4'b0000, 2'b01,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL lw_x2: got %h required %h", got, e);
        end
        drive(32'h0021_01B3, 32'h304);
        checks++;
        if (id_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: id_ready got %b required 0", id_ready);
        end
        n = 0;
        while (id_ready !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: stall cycles %0d ex_valid %b required 1 and 0", n, ex_valid);
        end
        exp_q.push_back(mk(32'h304, 32'd0, 5'd2, 5'd2, 5'd3, 2'b00, 1'b0, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add_after_bubble: got %h required %h", got, e);
        end
        // load into x0 never stalls its consumer
        drive(32'h0000_A003, 32'h308);
        exp_q.push_back(mk(32'h308, 32'd0, 5'd1, 5'd0, 5'd0, 2'b00, 1'b1, 4'b0000, 2'b01,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL lw_x0: got %h required %h", got, e);
        end
        drive(32'h0000_01B3, 32'h30C);
        checks++;
        if (id_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_stall: id_ready got %b required 1", id_ready);
        end
        exp_q.push_back(mk(32'h30C, 32'd0, 5'd0, 5'd0, 5'd3, 2'b00, 1'b0, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add_x0: got %h required %h", got, e);
        end
        // flush coinciding with a load-use hazard: one empty cycle only
        drive(32'h0000_A103, 32'h310);
        step();
        drive(32'h0021_01B3, 32'h314);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_hazard: ex_valid %b id_ready %b required 0 and 1", ex_valid, id_ready);
        end
        exp_q.push_back(mk(32'h314, 32'd0, 5'd2, 5'd2, 5'd3, 2'b00, 1'b0, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = exp_q.pop_front(); got = snap(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add_after_flush: got %h required %h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        ex_t e, got;
        logic [31:0] insts [3];
        insts[0] = 32'hFE00_0EE3;
        insts[1] = 32'h1234_52B7;
        insts[2] = 32'h4030_D093;
        exp_q.push_back(mk(32'h400, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd29, 2'b00, 1'b0, 4'b1000,
                           2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h404, 32'h1234_5000, 5'd8, 5'd3, 5'd5, 2'b10, 1'b1, 4'b0000,
                           2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h408, 32'h0000_0403, 5'd1, 5'd3, 5'd1, 2'b00, 1'b1, 4'b1101,
                           2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            drive(insts[i], 32'h400 + 32'(4 * i));
            step();
            e = exp_q.pop_front(); got = snap(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL imm_seq%0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_hold_flush();
        ex_t held, got;
        drive(32'h0050_0093, 32'h500);
        exp_q.push_back(mk(32'h500, 32'd5, 5'd0, 5'd5, 5'd1, 2'b00, 1'b1, 4'b0000, 2'b00,
                           1'b0, 1'b0, 1'b1, 1'b0));
        step();
        held = exp_q.pop_front();
        ex_ready = 1'b0;
        drive(32'h1234_52B7, 32'h504);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (id_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready%0d: got %b required 0", i, id_ready);
            end
            step();
            got = snap(); checks++;
            if (got !== held) begin
                errors++;
                $display("FAIL hold%0d: got %h required %h", i, got, held);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_hold: ex_valid got %b required 0", ex_valid);
        end
        ex_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [31:0] insts [2];
        insts[0] = 32'hFFFF_FFFF;
        insts[1] = 32'h0000_0010;
        for (int i = 0; i < 2; i++) begin
            drive(insts[i], 32'h600 + 32'(4 * i));
            step();
            checks++;
            if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_rw, ex_branch, ex_jump} !== 6'b110000) begin
                errors++;
                $display("FAIL illegal%0d: valid/ill/rw/mrw/br/j got %b%b%b%b%b%b required 110000",
                         i, ex_valid, ex_illegal, ex_reg_write, ex_mem_rw, ex_branch, ex_jump);
            end
        end
        if_valid = 1'b0;
        step();
        checks++;
        if (ex_valid !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drain: ex_valid %b queue %0d required 0 and 0", ex_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_hold_flush();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end

endmodule
